// File: rtl/pag_refill_seq_if.sv
// Memory read handshake between the page-refill sequencer and the MBOX.
// The sequencer is the master: it issues the request and receives the data.
interface pag_refill_seq_if;
  logic        mem_req;
  logic [21:0] mem_addr;
  logic        mem_ack;
  logic        mem_valid;
  logic [35:0] mem_data;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_valid, mem_data
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_valid, mem_data
  );
endinterface

// File: rtl/pag_refill_seq.sv
// Page-refill sequencer: fetches a page-table word on a miss and writes the
// selected half-word into the page-table RAM, or reports a page fail.
module pag_refill_seq #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             refill_req,
  input  logic             abort,
  input  logic             vma_user,
  input  logic [12:0]      va,
  input  logic [12:0]      ubr,
  input  logic [12:0]      ebr,
  pag_refill_seq_if.master mem,
  output logic             pt_wr,
  output logic [8:0]       pt_index,
  output logic [17:0]      pt_entry,
  output logic             page_refill_t4,
  output logic             ubr_sel,
  output logic             busy,
  output logic             refill_done,
  output logic             page_fail,
  output logic [1:0]       fail_code
);

  typedef enum logic [3:0] {
    IDLE, T1, REQ, WAIT, DRAIN, CHK, T4, DONE, FAIL
  } state_t;

  state_t      state, next_state;
  logic [12:0] va_q;
  logic        user_q;
  logic [TO_W-1:0] cnt;
  logic [17:0] half_q;
  logic [21:0] addr_q;
  logic        ubr_sel_q;
  logic [1:0]  code_q;

  logic        timeout, capture, cnt_clr, code_set;
  logic [1:0]  code_val;
  logic        per_page;
  logic [12:0] base;
  logic [8:0]  off;
  logic [17:0] half_sel;

  // Bit n of the PDP-10 numbered fields maps to vector bit (last - n).
  assign timeout  = (cnt == TO_W'(TIMEOUT - 1));
  assign half_sel = va_q[0] ? mem.mem_data[17:0] : mem.mem_data[35:18];
  assign per_page = ~va_q[8] & (va_q[7:5] == 3'b111);

  always_comb begin
    base = ebr;
    off  = 9'd0;
    if (user_q) begin
      base = ubr;
      off  = {1'b0, va_q[8:1]};
    end else if (per_page) begin
      base = ubr;
      off  = 9'o400 | {5'b0, va_q[4:1]};
    end else if (va_q[8]) begin
      off  = {1'b0, va_q[8:1]};
    end else begin
      off  = 9'o600 + {2'b0, va_q[7:1]};
    end
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    cnt_clr    = 1'b0;
    code_set   = 1'b0;
    code_val   = 2'd0;
    case (state)
      IDLE: if (refill_req) next_state = T1;
      T1: begin
        cnt_clr = 1'b1;
        if (abort) begin
          next_state = FAIL; code_set = 1'b1; code_val = 2'd2;
        end else begin
          next_state = REQ;
        end
      end
      REQ: begin
        if (mem.mem_ack && mem.mem_valid) begin
          if (abort) begin
            next_state = FAIL; code_set = 1'b1; code_val = 2'd2;
          end else begin
            next_state = CHK; capture = 1'b1;
          end
        end else if (mem.mem_ack) begin
          cnt_clr    = 1'b1;
          next_state = abort ? DRAIN : WAIT;
        end else if (abort) begin
          next_state = FAIL; code_set = 1'b1; code_val = 2'd2;
        end else if (timeout) begin
          next_state = FAIL; code_set = 1'b1; code_val = 2'd1;
        end
      end
      WAIT: begin
        if (mem.mem_valid) begin
          if (abort) begin
            next_state = FAIL; code_set = 1'b1; code_val = 2'd2;
          end else begin
            next_state = CHK; capture = 1'b1;
          end
        end else if (abort) begin
          next_state = DRAIN;
        end else if (timeout) begin
          next_state = FAIL; code_set = 1'b1; code_val = 2'd1;
        end
      end
      // An accepted read must still be drained before the fail is reported.
      DRAIN: if (mem.mem_valid || timeout) begin
        next_state = FAIL; code_set = 1'b1; code_val = 2'd2;
      end
      CHK: begin
        code_set = 1'b1;
        if (abort) begin
          next_state = FAIL; code_val = 2'd2;
        end else if (half_q[17:15] == 3'b000) begin
          next_state = FAIL; code_val = 2'd0;
        end else begin
          next_state = T4; code_set = 1'b0;
        end
      end
      T4:      next_state = DONE;
      DONE:    next_state = IDLE;
      FAIL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      va_q      <= '0;
      user_q    <= 1'b0;
      cnt       <= '0;
      half_q    <= '0;
      addr_q    <= '0;
      ubr_sel_q <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      state <= next_state;
      if (state == IDLE && refill_req) begin
        va_q   <= va;
        user_q <= vma_user;
        code_q <= 2'd0;
      end
      if (state == T1) begin
        addr_q    <= {base, off};
        ubr_sel_q <= user_q | per_page;
      end
      if (cnt_clr)
        cnt <= '0;
      else if (state == REQ || state == WAIT || state == DRAIN)
        cnt <= cnt + TO_W'(1);
      if (capture)  half_q <= half_sel;
      if (code_set) code_q <= code_val;
    end
  end

  assign mem.mem_req     = (state == REQ);
  assign mem.mem_addr    = addr_q;
  assign ubr_sel         = ubr_sel_q;
  assign pt_wr           = (state == T4);
  assign page_refill_t4  = (state == T4);
  assign pt_index        = (state == T4) ? va_q[8:0] : 9'd0;
  assign pt_entry        = (state == T4) ? half_q : 18'd0;
  assign busy            = (state != IDLE);
  assign refill_done     = (state == DONE);
  assign page_fail       = (state == FAIL);
  assign fail_code       = code_q;

endmodule

// File: tb/tb_pag_refill_seq.sv
// Directed self-checking bench for pag_refill_seq with hand-computed vectors.
module tb_pag_refill_seq;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        refill_req = 1'b0;
  logic        abort = 1'b0;
  logic        vma_user = 1'b0;
  logic [12:0] va = '0;
  logic [12:0] ubr = '0;
  logic [12:0] ebr = '0;
  logic        pt_wr, page_refill_t4, ubr_sel, busy, refill_done, page_fail;
  logic [8:0]  pt_index;
  logic [17:0] pt_entry;
  logic [1:0]  fail_code;
  int checks = 0;
  int failures = 0;

  pag_refill_seq_if mem_bus ();

  pag_refill_seq #(.TIMEOUT(64), .TO_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .refill_req(refill_req), .abort(abort),
    .vma_user(vma_user), .va(va), .ubr(ubr), .ebr(ebr), .mem(mem_bus),
    .pt_wr(pt_wr), .pt_index(pt_index), .pt_entry(pt_entry),
    .page_refill_t4(page_refill_t4), .ubr_sel(ubr_sel), .busy(busy),
    .refill_done(refill_done), .page_fail(page_fail), .fail_code(fail_code)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_valid = 1'b0;
    mem_bus.mem_data  = '0;
    ubr = 13'h0A5;
    ebr = 13'h1C3;
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_bus.mem_req, 0);
    check("rst_mem_addr", mem_bus.mem_addr, 0);
    check("rst_pt_wr", pt_wr, 0);
    check("rst_fail_code", fail_code, 0);
    #10 reset_n = 1'b1;
    tick();

    // User refill, page 9'o123, right half.
    vma_user = 1'b1; va = {4'h0, 9'o123}; refill_req = 1'b1;
    tick();
    refill_req = 1'b0;
    check("u_busy_t1", busy, 1);
    check("u_req_t1", mem_bus.mem_req, 0);
    tick();
    check("u_addr", mem_bus.mem_addr, {13'h0A5, 9'o051});
    check("u_ubr_sel", ubr_sel, 1);
    check("u_mem_req", mem_bus.mem_req, 1);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    check("u_req_drop", mem_bus.mem_req, 0);
    tick();
    tick();
    mem_bus.mem_valid = 1'b1; mem_bus.mem_data = {18'o0, 18'o500123};
    tick();
    mem_bus.mem_valid = 1'b0;
    check("u_no_wr_chk", pt_wr, 0);
    tick();
    check("u_pt_wr", pt_wr, 1);
    check("u_t4", page_refill_t4, 1);
    check("u_entry", pt_entry, 18'o500123);
    check("u_index", pt_index, 9'o123);
    tick();
    check("u_done", refill_done, 1);
    check("u_wr_off", pt_wr, 0);
    tick();
    check("u_idle", busy, 0);
    check("u_done_off", refill_done, 0);

    // Exec page 9'o017 via ebr, never acknowledged: timeout.
    vma_user = 1'b0; va = {4'h0, 9'o017}; refill_req = 1'b1;
    tick();
    refill_req = 1'b0;
    tick();
    check("x_addr", mem_bus.mem_addr, {13'h1C3, 9'o607});
    check("x_ubr_sel", ubr_sel, 0);
    for (int i = 0; i < 63; i++) tick();
    check("to_not_yet", page_fail, 0);
    check("to_req_held", mem_bus.mem_req, 1);
    tick();
    check("to_fail", page_fail, 1);
    check("to_code", fail_code, 1);
    check("to_req_low", mem_bus.mem_req, 0);
    tick();
    check("to_idle", busy, 0);
    check("to_code_held", fail_code, 1);

    // Exec per-process page 9'o345 with empty right half: no-access fail.
    va = {4'h0, 9'o345}; refill_req = 1'b1;
    tick();
    refill_req = 1'b0;
    check("p_code_clr", fail_code, 0);
    tick();
    check("p_addr", mem_bus.mem_addr, {13'h0A5, 9'o402});
    check("p_ubr_sel", ubr_sel, 1);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_valid = 1'b1;
    mem_bus.mem_data = {18'o777777, 18'o077777};
    tick();
    mem_bus.mem_ack = 1'b0; mem_bus.mem_valid = 1'b0;
    tick();
    check("na_fail", page_fail, 1);
    check("na_code", fail_code, 0);
    check("na_no_wr", pt_wr, 0);
    check("na_no_t4", page_refill_t4, 0);
    tick();
    check("na_idle", busy, 0);

    // Abort in WAIT drains the read; refill_req while busy is ignored.
    vma_user = 1'b1; va = {4'h0, 9'o123}; refill_req = 1'b1;
    tick();
    refill_req = 1'b0;
    tick();
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    abort = 1'b1; refill_req = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 1);
    check("ab_no_fail", page_fail, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ab_no_wr", pt_wr, 0);
    end
    mem_bus.mem_valid = 1'b1; mem_bus.mem_data = {18'o0, 18'o500123};
    tick();
    mem_bus.mem_valid = 1'b0; refill_req = 1'b0;
    check("ab_fail", page_fail, 1);
    check("ab_code", fail_code, 2);
    check("ab_wr", pt_wr, 0);
    tick();
    check("ab_idle", busy, 0);
    tick();
    check("ab_not_queued", busy, 0);

    // Exec page 9'o456 (va[18]=1); abort with refill_req in IDLE loses.
    vma_user = 1'b0; va = {4'h0, 9'o456}; refill_req = 1'b1; abort = 1'b1;
    tick();
    refill_req = 1'b0; abort = 1'b0;
    check("idle_abort_busy", busy, 1);
    tick();
    check("e_addr", mem_bus.mem_addr, {13'h1C3, 9'o227});
    check("e_ubr_sel", ubr_sel, 0);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_addr", mem_bus.mem_addr, 0);
    check("mr_ubr_sel", ubr_sel, 0);
    check("mr_req", mem_bus.mem_req, 0);
    #3 reset_n = 1'b1;
    tick();

    // Fresh refill after reset completes with the left half.
    refill_req = 1'b1;
    tick();
    refill_req = 1'b0;
    tick();
    check("r_addr", mem_bus.mem_addr, {13'h1C3, 9'o227});
    mem_bus.mem_ack = 1'b1; mem_bus.mem_valid = 1'b1;
    mem_bus.mem_data = {18'o700456, 18'o0};
    tick();
    mem_bus.mem_ack = 1'b0; mem_bus.mem_valid = 1'b0;
    tick();
    check("r_pt_wr", pt_wr, 1);
    check("r_entry", pt_entry, 18'o700456);
    check("r_index", pt_index, 9'o456);
    tick();
    check("r_done", refill_done, 1);
    check("r_no_fail", page_fail, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
